// File: rtl/decode_pkg.sv
// Shared decode constants for the ID stage: MIPS opcodes/functs, control-bus bit
// positions and ALU function codes.
package decode_pkg;

    localparam int CB_W = 12;

    // Control bus layout {EX[4:0], MA[4:0], WB[1:0]}
    localparam int CB_REG_DST    = 11;
    localparam int CB_ALU_SRC    = 10;
    localparam int CB_SHIFT_SA   = 9;
    localparam int CB_LINK       = 8;
    localparam int CB_MD         = 7;
    localparam int CB_MEM_RD     = 6;
    localparam int CB_MEM_WR     = 5;
    localparam int CB_WIDTH      = 3;
    localparam int CB_UNSIGNED   = 2;
    localparam int CB_REG_WR     = 1;
    localparam int CB_MEM_TO_REG = 0;

    localparam logic [1:0] MW_BYTE = 2'b00;
    localparam logic [1:0] MW_HALF = 2'b01;
    localparam logic [1:0] MW_WORD = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;
    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_JALR  = 6'd9;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    // I-type ALU ops reuse the matching R-type funct codes
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_SUBU = 6'b100011;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_SLTU = 6'b101011;
    localparam logic [5:0] ALU_LUI  = 6'b001111;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/decode_stage_scoreboard_fwd_mux.sv
// Operand forwarding select: lowest-indexed matching source wins, $0 is hard zero.
module fwd_mux
    import decode_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int N_FWD   = 2
) (
    input  logic [NB_REG-1:0]        reg_num,
    input  logic [NB_DATA-1:0]       rf_data,
    input  logic [N_FWD-1:0]         fwd_valid,
    input  logic [N_FWD-1:0]         fwd_load,
    input  logic [N_FWD*NB_REG-1:0]  fwd_num,
    input  logic [N_FWD*NB_DATA-1:0] fwd_data,
    output logic [NB_DATA-1:0]       data,
    output logic                     load
);

    always_comb begin
        data = rf_data;
        load = 1'b0;
        if (reg_num == '0) begin
            data = '0;
        end else begin
            // Scan oldest to youngest so the youngest match overwrites last
            for (int k = N_FWD - 1; k >= 0; k--) begin
                if (fwd_valid[k] && (fwd_num[k*NB_REG +: NB_REG] == reg_num)) begin
                    data = fwd_data[k*NB_DATA +: NB_DATA];
                    load = fwd_load[k];
                end
            end
        end
    end

endmodule

// File: rtl/decode_stage_scoreboard.sv
// MIPS ID stage: decode, forwarding, hazard stall, ID-resolved branches and HI/LO busy tracking.
//  state   | meaning
//  MD_IDLE | HI/LO free, MULT*/DIV*/MFHI/MFLO may issue
//  MD_BUSY | md_cnt cycles of MULT/DIV latency remain
module decode_stage_scoreboard
    import decode_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDRESS = 32,
    parameter int NB_REG     = 5,
    parameter int N_FWD      = 2,
    parameter int MULT_LAT   = 4,
    parameter int DIV_LAT    = 32,
    parameter bit DELAY_SLOT = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_if_valid,
    output logic                     o_if_ready,
    input  logic [31:0]              i_instruction,
    input  logic [NB_ADDRESS-1:0]    i_pc,
    output logic [NB_REG-1:0]        o_rs_addr,
    output logic [NB_REG-1:0]        o_rt_addr,
    input  logic [NB_DATA-1:0]       i_rs_data,
    input  logic [NB_DATA-1:0]       i_rt_data,
    input  logic [N_FWD-1:0]         i_fwd_valid,
    input  logic [N_FWD-1:0]         i_fwd_load,
    input  logic [N_FWD*NB_REG-1:0]  i_fwd_num,
    input  logic [N_FWD*NB_DATA-1:0] i_fwd_data,
    input  logic                     i_ex_ready,
    output logic                     o_ex_valid,
    output logic [NB_DATA-1:0]       o_bus_a,
    output logic [NB_DATA-1:0]       o_bus_b,
    output logic [NB_REG-1:0]        o_rs_num,
    output logic [NB_REG-1:0]        o_rt_num,
    output logic [NB_REG-1:0]        o_rd_num,
    output logic [NB_DATA-1:0]       o_ext_literal,
    output logic [NB_DATA-1:0]       o_ext_sa,
    output logic [NB_ADDRESS-1:0]    o_pc_link,
    output logic [CB_W-1:0]          o_control_bus,
    output logic [5:0]               o_alu_op,
    output logic                     o_branch,
    output logic [NB_ADDRESS-1:0]    o_branch_addr,
    output logic                     o_if_kill,
    output logic                     o_md_busy,
    output logic [15:0]              o_stall_cycles
);

    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [5:0]         opcode, func;
    logic [NB_REG-1:0]  rs, rt, rd;
    logic [4:0]         shamt;
    logic [15:0]        imm;
    logic [25:0]        idx;

    assign opcode = i_instruction[31:26];
    assign rs     = i_instruction[25:21];
    assign rt     = i_instruction[20:16];
    assign rd     = i_instruction[15:11];
    assign shamt  = i_instruction[10:6];
    assign func   = i_instruction[5:0];
    assign imm    = i_instruction[15:0];
    assign idx    = i_instruction[25:0];

    assign o_rs_addr = rs;
    assign o_rt_addr = rt;

    logic [NB_DATA-1:0] bus_a, bus_b;
    logic               rs_load, rt_load;

    fwd_mux #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .N_FWD(N_FWD)) u_fwd_rs (
        .reg_num(rs), .rf_data(i_rs_data), .fwd_valid(i_fwd_valid), .fwd_load(i_fwd_load),
        .fwd_num(i_fwd_num), .fwd_data(i_fwd_data), .data(bus_a), .load(rs_load)
    );

    fwd_mux #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .N_FWD(N_FWD)) u_fwd_rt (
        .reg_num(rt), .rf_data(i_rt_data), .fwd_valid(i_fwd_valid), .fwd_load(i_fwd_load),
        .fwd_num(i_fwd_num), .fwd_data(i_fwd_data), .data(bus_b), .load(rt_load)
    );

    logic [CB_W-1:0]   ctrl;
    logic [5:0]        alu_op;
    logic [NB_REG-1:0] dst;
    logic use_rs, use_rt, is_mult, is_div, is_mfhl, is_jump, is_jreg, is_beq, is_bne;

    always_comb begin
        ctrl    = '0;
        alu_op  = ALU_ADDU;
        dst     = rt;
        use_rs  = 1'b1;
        use_rt  = 1'b0;
        is_mult = 1'b0;
        is_div  = 1'b0;
        is_mfhl = 1'b0;
        is_jump = 1'b0;
        is_jreg = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rt            = 1'b1;
                dst               = rd;
                alu_op            = func;
                ctrl[CB_REG_DST]  = 1'b1;
                ctrl[CB_REG_WR]   = 1'b1;
                case (func)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        use_rs            = 1'b0;
                        ctrl[CB_SHIFT_SA] = 1'b1;
                    end
                    FN_JR: begin
                        use_rt           = 1'b0;
                        is_jreg          = 1'b1;
                        ctrl[CB_REG_DST] = 1'b0;
                        ctrl[CB_REG_WR]  = 1'b0;
                    end
                    FN_JALR: begin
                        use_rt        = 1'b0;
                        is_jreg       = 1'b1;
                        ctrl[CB_LINK] = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        use_rs  = 1'b0;
                        use_rt  = 1'b0;
                        is_mfhl = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        use_rt           = 1'b0;
                        ctrl[CB_MD]      = 1'b1;
                        ctrl[CB_REG_DST] = 1'b0;
                        ctrl[CB_REG_WR]  = 1'b0;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        is_mult          = (func == FN_MULT) || (func == FN_MULTU);
                        is_div           = (func == FN_DIV)  || (func == FN_DIVU);
                        ctrl[CB_MD]      = 1'b1;
                        ctrl[CB_REG_DST] = 1'b0;
                        ctrl[CB_REG_WR]  = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_J: begin
                use_rs  = 1'b0;
                is_jump = 1'b1;
            end
            OP_JAL: begin
                use_rs          = 1'b0;
                is_jump         = 1'b1;
                dst             = NB_REG'(31);
                ctrl[CB_LINK]   = 1'b1;
                ctrl[CB_REG_WR] = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                use_rt = 1'b1;
                is_beq = (opcode == OP_BEQ);
                is_bne = (opcode == OP_BNE);
                alu_op = ALU_SUBU;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl[CB_ALU_SRC] = 1'b1;
                ctrl[CB_REG_WR]  = 1'b1;
                use_rs           = (opcode != OP_LUI);
                case (opcode)
                    OP_ADDI:  alu_op = ALU_ADD;
                    OP_SLTI:  alu_op = ALU_SLT;
                    OP_SLTIU: alu_op = ALU_SLTU;
                    OP_ANDI:  alu_op = ALU_AND;
                    OP_ORI:   alu_op = ALU_OR;
                    OP_XORI:  alu_op = ALU_XOR;
                    OP_LUI:   alu_op = ALU_LUI;
                    default:  alu_op = ALU_ADDU;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl[CB_ALU_SRC]      = 1'b1;
                ctrl[CB_MEM_RD]       = 1'b1;
                ctrl[CB_REG_WR]       = 1'b1;
                ctrl[CB_MEM_TO_REG]   = 1'b1;
                ctrl[CB_UNSIGNED]     = (opcode == OP_LBU) || (opcode == OP_LHU);
                ctrl[CB_WIDTH +: 2]   = (opcode == OP_LW) ? MW_WORD :
                                        ((opcode == OP_LH) || (opcode == OP_LHU)) ? MW_HALF : MW_BYTE;
            end
            OP_SB, OP_SH, OP_SW: begin
                use_rt              = 1'b1;
                ctrl[CB_ALU_SRC]    = 1'b1;
                ctrl[CB_MEM_WR]     = 1'b1;
                ctrl[CB_WIDTH +: 2] = (opcode == OP_SW) ? MW_WORD :
                                      (opcode == OP_SH) ? MW_HALF : MW_BYTE;
            end
            default: ;
        endcase
    end

    md_state_t        md_state, md_state_nx;
    logic [MD_W-1:0]  md_cnt, md_cnt_nx;
    logic             load_use, md_hazard, advance, accept, taken;

    assign o_md_busy  = (md_state == MD_BUSY);
    assign load_use   = (use_rs && rs_load) || (use_rt && rt_load);
    assign md_hazard  = o_md_busy && (is_mult || is_div || is_mfhl);
    assign advance    = !o_ex_valid || i_ex_ready;
    assign o_if_ready = !(load_use || md_hazard) && advance;
    assign accept     = i_if_valid && o_if_ready;

    assign taken     = is_jump || is_jreg || (is_beq && (bus_a == bus_b)) || (is_bne && (bus_a != bus_b));
    assign o_branch  = accept && taken;
    assign o_if_kill = o_branch && !DELAY_SLOT;

    always_comb begin
        if (is_jump)
            o_branch_addr = {i_pc[NB_ADDRESS-1:28], idx, 2'b00};
        else if (is_jreg)
            o_branch_addr = NB_ADDRESS'(bus_a);
        else
            o_branch_addr = i_pc + {{(NB_ADDRESS-18){imm[15]}}, imm, 2'b00};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            md_state <= md_state_nx;
            md_cnt   <= md_cnt_nx;
        end
    end

    always_comb begin
        md_state_nx = md_state;
        md_cnt_nx   = md_cnt;
        case (md_state)
            MD_IDLE: begin
                if (accept && is_mult) begin
                    md_cnt_nx   = MD_W'(MULT_LAT);
                    md_state_nx = MD_BUSY;
                end else if (accept && is_div) begin
                    md_cnt_nx   = MD_W'(DIV_LAT);
                    md_state_nx = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_cnt_nx = md_cnt - MD_W'(1);
                if (md_cnt == MD_W'(1))
                    md_state_nx = MD_IDLE;
            end
            default: md_state_nx = MD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ex_valid    <= 1'b0;
            o_bus_a       <= '0;
            o_bus_b       <= '0;
            o_rs_num      <= '0;
            o_rt_num      <= '0;
            o_rd_num      <= '0;
            o_ext_literal <= '0;
            o_ext_sa      <= '0;
            o_pc_link     <= '0;
            o_control_bus <= '0;
            o_alu_op      <= '0;
        end else if (advance) begin
            if (accept) begin
                o_ex_valid    <= 1'b1;
                o_bus_a       <= bus_a;
                o_bus_b       <= bus_b;
                o_rs_num      <= rs;
                o_rt_num      <= rt;
                o_rd_num      <= dst;
                o_ext_literal <= {{(NB_DATA-16){imm[15]}}, imm};
                o_ext_sa      <= {{(NB_DATA-5){1'b0}}, shamt};
                o_pc_link     <= i_pc;
                o_control_bus <= ctrl;
                o_alu_op      <= alu_op;
            end else begin
                o_ex_valid    <= 1'b0;
                o_control_bus <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_stall_cycles <= '0;
        else if (i_if_valid && !o_if_ready && (o_stall_cycles != 16'hFFFF))
            o_stall_cycles <= o_stall_cycles + 16'd1;
    end

endmodule

// File: tb/tb_decode_stage_scoreboard.sv
// Directed bench for decode_stage_scoreboard: forwarding, load-use and HI/LO stalls,
// branch resolution, EX back-pressure and reset during a divide.
module tb_decode_stage_scoreboard;

    localparam int NB_DATA = 32;
    localparam int NB_ADDRESS = 32;
    localparam int NB_REG = 5;
    localparam int N_FWD = 2;

    logic                     i_clk = 1'b0;
    logic                     i_reset;
    logic                     i_if_valid;
    logic                     o_if_ready;
    logic [31:0]              i_instruction;
    logic [NB_ADDRESS-1:0]    i_pc;
    logic [NB_REG-1:0]        o_rs_addr, o_rt_addr;
    logic [NB_DATA-1:0]       i_rs_data, i_rt_data;
    logic [N_FWD-1:0]         i_fwd_valid, i_fwd_load;
    logic [N_FWD*NB_REG-1:0]  i_fwd_num;
    logic [N_FWD*NB_DATA-1:0] i_fwd_data;
    logic                     i_ex_ready;
    logic                     o_ex_valid;
    logic [NB_DATA-1:0]       o_bus_a, o_bus_b, o_ext_literal, o_ext_sa;
    logic [NB_REG-1:0]        o_rs_num, o_rt_num, o_rd_num;
    logic [NB_ADDRESS-1:0]    o_pc_link, o_branch_addr;
    logic [11:0]              o_control_bus;
    logic [5:0]               o_alu_op;
    logic                     o_branch, o_if_kill, o_md_busy;
    logic [15:0]              o_stall_cycles;

    logic [NB_DATA-1:0] rf [32];
    int checks = 0;
    int errors = 0;

    assign i_rs_data = rf[o_rs_addr];
    assign i_rt_data = rf[o_rt_addr];

    always #5 i_clk = ~i_clk;

    decode_stage_scoreboard #(
        .NB_DATA(NB_DATA), .NB_ADDRESS(NB_ADDRESS), .NB_REG(NB_REG), .N_FWD(N_FWD),
        .MULT_LAT(4), .DIV_LAT(32), .DELAY_SLOT(1'b0)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_if_valid(i_if_valid), .o_if_ready(o_if_ready),
        .i_instruction(i_instruction), .i_pc(i_pc), .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_fwd_valid(i_fwd_valid),
        .i_fwd_load(i_fwd_load), .i_fwd_num(i_fwd_num), .i_fwd_data(i_fwd_data),
        .i_ex_ready(i_ex_ready), .o_ex_valid(o_ex_valid), .o_bus_a(o_bus_a), .o_bus_b(o_bus_b),
        .o_rs_num(o_rs_num), .o_rt_num(o_rt_num), .o_rd_num(o_rd_num),
        .o_ext_literal(o_ext_literal), .o_ext_sa(o_ext_sa), .o_pc_link(o_pc_link),
        .o_control_bus(o_control_bus), .o_alu_op(o_alu_op), .o_branch(o_branch),
        .o_branch_addr(o_branch_addr), .o_if_kill(o_if_kill), .o_md_busy(o_md_busy),
        .o_stall_cycles(o_stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_fwd(input int k, input logic v, input logic ld,
                           input logic [4:0] num, input logic [31:0] data);
        i_fwd_valid[k]          = v;
        i_fwd_load[k]           = ld;
        i_fwd_num[k*NB_REG +: NB_REG]    = num;
        i_fwd_data[k*NB_DATA +: NB_DATA] = data;
    endtask

    function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input int fn);
        r_op = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_op(input int op, input int rs, input int rt, input int im);
        i_op = {6'(op), 5'(rs), 5'(rt), 16'(im)};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(100 + i);
        rf[0] = '0;
        i_reset = 1'b1;
        i_if_valid = 1'b0;
        i_instruction = '0;
        i_pc = '0;
        i_ex_ready = 1'b1;
        i_fwd_valid = '0; i_fwd_load = '0; i_fwd_num = '0; i_fwd_data = '0;
        repeat (2) tick();
        check("rst_ex_valid", o_ex_valid, 0);
        check("rst_control", o_control_bus, 0);
        check("rst_md_busy", o_md_busy, 0);
        check("rst_stall", o_stall_cycles, 0);
        check("rst_bus_a", o_bus_a, 0);
        i_reset = 1'b0;

        // addi $1,$0,5
        i_instruction = i_op(8, 0, 1, 5); i_pc = 32'h10; i_if_valid = 1'b1;
        #1;
        check("addi_ready", o_if_ready, 1);
        check("addi_no_branch", o_branch, 0);
        tick();
        check("addi_ex_valid", o_ex_valid, 1);
        check("addi_control", o_control_bus, 12'h402);
        check("addi_alu_op", o_alu_op, 6'h20);
        check("addi_rd", o_rd_num, 1);
        check("addi_literal", o_ext_literal, 5);
        check("addi_pc_link", o_pc_link, 32'h10);

        // add $2,$1,$1 with $1 forwarded from EX
        i_instruction = r_op(1, 1, 2, 32); set_fwd(0, 1, 0, 1, 5);
        #1;
        check("add_fwd_ready", o_if_ready, 1);
        tick();
        check("add_fwd_bus_a", o_bus_a, 5);
        check("add_fwd_bus_b", o_bus_b, 5);
        check("add_control", o_control_bus, 12'h802);
        check("add_rd", o_rd_num, 2);
        check("add_no_stall", o_stall_cycles, 0);

        // add $5,$1,$2: rs from source 1, rt from source 0
        i_instruction = r_op(1, 2, 5, 32); set_fwd(0, 1, 0, 2, 9); set_fwd(1, 1, 0, 1, 77);
        tick();
        check("prio_bus_a", o_bus_a, 77);
        check("prio_bus_b", o_bus_b, 9);
        set_fwd(0, 1, 0, 1, 11);
        i_instruction = r_op(1, 3, 5, 32);
        tick();
        check("prio_young_wins", o_bus_a, 11);
        check("prio_rf_read", o_bus_b, 103);

        // $0 ignores a forwarding source targeting register 0
        i_instruction = r_op(0, 0, 6, 32); set_fwd(0, 1, 0, 0, 55); set_fwd(1, 0, 0, 0, 0);
        tick();
        check("zero_bus_a", o_bus_a, 0);
        check("zero_bus_b", o_bus_b, 0);

        // load-use: lw $3 in EX, add $4,$3,$0 stalls one cycle
        i_instruction = r_op(3, 0, 4, 32); set_fwd(0, 1, 1, 3, 0);
        #1;
        check("lu_ready_low", o_if_ready, 0);
        tick();
        check("lu_bubble_valid", o_ex_valid, 0);
        check("lu_bubble_ctrl", o_control_bus, 0);
        check("lu_stall_cnt", o_stall_cycles, 1);
        set_fwd(0, 0, 0, 0, 0); set_fwd(1, 1, 0, 3, 33);
        #1;
        check("lu_ready_back", o_if_ready, 1);
        tick();
        check("lu_issue_valid", o_ex_valid, 1);
        check("lu_issue_bus_a", o_bus_a, 33);
        check("lu_stall_hold", o_stall_cycles, 1);

        // beq $1,$2,4 at pc+4=0x100 with equal forwarded operands
        i_instruction = i_op(4, 1, 2, 4); i_pc = 32'h100;
        set_fwd(0, 1, 0, 1, 7); set_fwd(1, 1, 0, 2, 7);
        #1;
        check("beq_branch", o_branch, 1);
        check("beq_addr", o_branch_addr, 32'h110);
        check("beq_kill", o_if_kill, 1);
        i_instruction = i_op(5, 1, 2, 4);
        #1;
        check("bne_not_taken", o_branch, 0);
        check("bne_no_kill", o_if_kill, 0);
        i_instruction = i_op(2, 0, 0, 32'h40); i_pc = 32'h3000_0008;
        #1;
        check("j_branch", o_branch, 1);
        check("j_addr", o_branch_addr, 32'h3000_0100);
        tick();
        check("j_control", o_control_bus, 0);

        // MULT then MFLO: four busy cycles of stall
        set_fwd(0, 0, 0, 0, 0); set_fwd(1, 0, 0, 0, 0);
        i_instruction = r_op(1, 2, 0, 24);
        tick();
        check("mult_busy", o_md_busy, 1);
        i_instruction = r_op(0, 0, 7, 18);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mflo_stall", o_if_ready, 0);
            check("mflo_busy", o_md_busy, 1);
            tick();
        end
        check("md_busy_drop", o_md_busy, 0);
        #1;
        check("mflo_ready", o_if_ready, 1);
        tick();
        check("mflo_valid", o_ex_valid, 1);
        check("mflo_control", o_control_bus, 12'h802);
        check("mflo_rd", o_rd_num, 7);
        check("mflo_stall_cnt", o_stall_cycles, 5);

        // EX back-pressure holds the ID/EX register and blocks a taken branch
        i_instruction = r_op(1, 1, 2, 32); set_fwd(0, 1, 0, 1, 5);
        tick();
        check("hold_load_valid", o_ex_valid, 1);
        i_ex_ready = 1'b0;
        i_instruction = i_op(4, 0, 0, 1); set_fwd(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ready_low", o_if_ready, 0);
            check("hold_no_branch", o_branch, 0);
            tick();
            check("hold_valid", o_ex_valid, 1);
            check("hold_bus_a", o_bus_a, 5);
            check("hold_control", o_control_bus, 12'h802);
        end
        i_ex_ready = 1'b1;
        #1;
        check("release_ready", o_if_ready, 1);
        check("release_branch", o_branch, 1);
        tick();
        check("release_stall_cnt", o_stall_cycles, 8);
        check("release_control", o_control_bus, 0);

        // reset in the middle of a DIV, with an accept-able addi presented
        i_instruction = r_op(1, 2, 0, 26);
        tick();
        check("div_busy", o_md_busy, 1);
        i_if_valid = 1'b0;
        repeat (3) tick();
        check("div_still_busy", o_md_busy, 1);
        i_reset = 1'b1; i_if_valid = 1'b1; i_instruction = i_op(8, 0, 1, 5);
        tick();
        check("rst_div_busy", o_md_busy, 0);
        check("rst_div_valid", o_ex_valid, 0);
        check("rst_div_stall", o_stall_cycles, 0);
        check("rst_div_ctrl", o_control_bus, 0);
        i_reset = 1'b0; i_if_valid = 1'b0;
        tick();
        check("post_rst_busy", o_md_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
